// File: rtl/ifu_axi_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ifu_axi_pkg;

    localparam int          XLEN          = 64;
    localparam logic [63:0] START_ADDR    = 64'h0000_0000_8000_0000;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_axi.sv
// Instruction fetch unit: one single-beat AXI4-Lite read per accepted pc,
// instruction handed to decode over a valid/ready handshake.
//
// state    | meaning
// IFU_IDLE | waiting for a fetch address
// IFU_ADDR | AR channel valid, waiting for arready
// IFU_DATA | waiting for the read beat
// IFU_OUT  | instruction presented to decode
module ifu_axi #(
    parameter int XLEN   = ifu_axi_pkg::XLEN,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_err,
    output logic              inst_misalign,
    output logic              inst_valid,
    input  logic              inst_ready
);
    import ifu_axi_pkg::*;

    ifu_state_t      state, state_nxt;
    logic            flush_pending;
    logic [XLEN-1:0] pc_q;
    logic            accept, misaligned, beat, drop;

    assign accept     = pc_valid & pc_ready;
    assign misaligned = (pc[1:0] != 2'b00);
    assign beat       = rvalid & (state == IFU_DATA);
    assign drop       = beat & (flush_pending | flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IFU_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IFU_IDLE: if (accept)             state_nxt = misaligned ? IFU_OUT : IFU_ADDR;
            IFU_ADDR: if (arready)            state_nxt = IFU_DATA;
            IFU_DATA: if (beat)               state_nxt = drop ? IFU_IDLE : IFU_OUT;
            IFU_OUT:  if (flush | inst_ready) state_nxt = IFU_IDLE;
            default:                          state_nxt = IFU_IDLE;
        endcase
    end

    // rst gates pc_ready directly so no address is taken while reset is held
    always_comb begin
        pc_ready   = rst & (state == IFU_IDLE) & ~flush;
        arvalid    = (state == IFU_ADDR);
        rready     = (state == IFU_DATA);
        inst_valid = (state == IFU_OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pending <= 1'b0;
            pc_q          <= '0;
            araddr        <= '0;
            inst          <= '0;
            inst_pc       <= '0;
            inst_err      <= 1'b0;
            inst_misalign <= 1'b0;
        end else begin
            if (beat)
                flush_pending <= 1'b0;
            else if (flush && (state == IFU_ADDR || state == IFU_DATA))
                flush_pending <= 1'b1;

            if (accept) begin
                pc_q   <= pc;
                araddr <= {pc[ADDR_W-1:3], 3'b000};
                if (misaligned) begin
                    inst          <= '0;
                    inst_pc       <= pc;
                    inst_err      <= 1'b0;
                    inst_misalign <= 1'b1;
                end
            end

            if (beat) begin
                inst          <= pc_q[2] ? rdata[63:32] : rdata[31:0];
                inst_pc       <= pc_q;
                inst_err      <= (rresp != AXI_RESP_OKAY);
                inst_misalign <= 1'b0;
            end
        end
    end

endmodule
